chunked_add_sub: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor. It is the successor to the team's fixed 4-bit ripple add/sub. Each clock it processes one CHUNK-bit slice of a WIDTH-bit operand pair, carrying between slices in a register. It adds status flags (carry/borrow, signed overflow, zero) and a start/busy/done handshake. It sits beside the datapath as a shared arithmetic unit where a full-width single-cycle carry chain is too long for the clock.

---
 rtl/chunked_add_sub.sv | 152 +++++++++++++++
 tb/tb_chunked_add_sub.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement add/sub that handles one CHUNK-bit slice per clock,
// with carry/borrow, signed-overflow and zero flags and a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; busy=0, done=0
// RUN    | one slice per clock; busy=1, sum holds partial slices
// DONE   | one-cycle done pulse; sum and flags valid; start here re-arms
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             zacc_q, zacc_d;

    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_c, sl_cmsb;
    logic             last_slice;
    logic             accept;

    // Returns {carry into MSB, carry out, slice sum}; kept in a function so the
    // ripple is expressed with local variables rather than a self-referencing net.
    function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] a,
                                                input logic [CHUNK-1:0] b,
                                                input logic             cin);
        logic [CHUNK:0]   c;
        logic [CHUNK-1:0] s;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        return {c[CHUNK-1], c[CHUNK], s};
    endfunction

    always_comb begin
        sl_a = opa_q[idx_q*CHUNK +: CHUNK];
        sl_b = opb_q[idx_q*CHUNK +: CHUNK];
        {sl_cmsb, sl_c, sl_s} = ripple(sl_a, sl_b, carry_q);
    end

    assign last_slice = (idx_q == IDXW'(N - 1));
    assign accept     = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        zacc_d  = zacc_q;

        case (state_q)
            S_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = sl_s;
                carry_d = sl_c;
                idx_d   = idx_q + 1'b1;
                zacc_d  = zacc_q & (sl_s == '0);
                if (last_slice) begin
                    cout_d  = sl_c;
                    ovf_d   = sl_cmsb ^ sl_c;
                    zero_d  = zacc_q & (sl_s == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Subtraction is A + ~B + 1: invert B here and seed the carry with M.
        if (accept) begin
            opa_d   = A;
            opb_d   = B ^ {WIDTH{M}};
            carry_d = M;
            idx_d   = '0;
            zacc_d  = 1'b1;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            zacc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            zacc_q  <= zacc_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: a 16/4 instance and a single-slice 16/16 instance.
module tb_chunked_add_sub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, M;
    logic [15:0] A, B;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] sum;

    logic        start_w, m_w;
    logic [15:0] a_w, b_w;
    logic        busy_w, done_w, cout_w, ovf_w, zero_w;
    logic [15:0] sum_w;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .M(M),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .A(a_w), .B(b_w), .M(m_w),
        .busy(busy_w), .done(done_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w), .zero(zero_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Waits up to 20 clocks for done; returns the number of edges waited (20 = timeout).
    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic m, input logic [15:0] e_sum,
                          input logic e_c, input logic e_v, input logic e_z);
        int k;
        @(negedge clk);
        A = a; B = b; M = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; M = ~m;
        check({tag, ".busy"}, busy, 1);
        wait_done(k);
        check({tag, ".lat"}, k, 4);
        check({tag, ".sum"}, sum, e_sum);
        check({tag, ".cout"}, cout, e_c);
        check({tag, ".ovf"}, ovf, e_v);
        check({tag, ".zero"}, zero, e_z);
        @(posedge clk); #1;
        check({tag, ".pulse"}, done, 0);
    endtask

    initial begin
        int k, j, pulses;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; M = 1'b0;
        start_w = 1'b0; a_w = '0; b_w = '0; m_w = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.sum", sum, 0);
        check("rst.flags", {cout, ovf, zero}, 0);
        rst_n = 1'b1;

        run_op("add",    16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
        run_op("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("subeq",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("ovfsub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("lowz",   16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // start pulsed on the 2nd RUN clock with other operands must be ignored
        @(negedge clk);
        A = 16'h00F0; B = 16'h0010; M = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; M = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);
        check("ign.lat", k + 2, 4);
        check("ign.sum", sum, 16'h0100);
        check("ign.flags", {cout, ovf, zero}, 3'b000);
        @(posedge clk); #1;
        check("ign.idle", {busy, done}, 2'b00);

        // start held high: back-to-back results every N+1 clocks
        @(negedge clk);
        A = 16'h0001; B = 16'h0002; M = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(k);
        check("b2b.lat", k, 4);
        check("b2b.sum0", sum, 16'h0003);
        j = 0;
        @(posedge clk); #1;
        j++;
        check("b2b.rebusy", busy, 1);
        wait_done(k);
        check("b2b.period", j + k, 5);
        check("b2b.sum1", sum, 16'h0003);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b.idle", {busy, done}, 2'b00);

        run_op("prerst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // reset at the 2nd RUN clock discards the operation
        @(negedge clk);
        A = 16'h1234; B = 16'h0FFF; M = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.sum", sum, 0);
        check("mrst.flags", {cout, ovf, zero}, 3'b000);
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("mrst.nodone", pulses, 0);
        run_op("postrst", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);

        // single-slice build: done one clock after the accept
        @(negedge clk);
        a_w = 16'h00FF; b_w = 16'hFF01; m_w = 1'b0; start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        check("w.busy", busy_w, 1);
        k = 0;
        while (!done_w && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("w.lat", k, 1);
        check("w.sum", sum_w, 16'h0000);
        check("w.flags", {cout_w, ovf_w, zero_w}, 3'b101);
        @(posedge clk); #1;
        check("w.pulse", done_w, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
